// File: rtl/exec_unit_if.sv
// Execute-stage bundle: decoded instruction fields and operands in,
// ALU results and next-PC targets out.
interface exec_unit_if;
    logic        clk_enable;
    logic [1:0]  alu_op;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        branch;
    logic        condition_met;
    logic        jump1;
    logic        jump2;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic [31:0] pc_plus4;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] tgt_addr_0;
    logic [31:0] tgt_addr_1;
    logic        delay;

    modport master (
        output clk_enable, alu_op, opcode, function_code, shamt, a, b,
               branch, condition_met, jump1, jump2, branch_addr, jump_addr, pc_plus4,
        input  alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1, delay
    );

    modport slave (
        input  clk_enable, alu_op, opcode, function_code, shamt, a, b,
               branch, condition_met, jump1, jump2, branch_addr, jump_addr, pc_plus4,
        output alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1, delay
    );
endinterface

// File: rtl/exec_unit.sv
// MIPS-I execute stage: ALU control decode, ALU with HI/LO, next-PC select,
// and the registered delay-slot target.
module exec_unit (
    input  logic         clk,
    input  logic         reset,
    exec_unit_if.slave   bus
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SRL   = 5'd3;
    localparam logic [4:0] OP_SRA   = 5'd4;
    localparam logic [4:0] OP_SLLV  = 5'd5;
    localparam logic [4:0] OP_SRLV  = 5'd6;
    localparam logic [4:0] OP_SRAV  = 5'd7;
    localparam logic [4:0] OP_MULT  = 5'd8;
    localparam logic [4:0] OP_MULTU = 5'd9;
    localparam logic [4:0] OP_DIV   = 5'd10;
    localparam logic [4:0] OP_DIVU  = 5'd11;
    localparam logic [4:0] OP_AND   = 5'd12;
    localparam logic [4:0] OP_OR    = 5'd13;
    localparam logic [4:0] OP_XOR   = 5'd14;
    localparam logic [4:0] OP_SLT   = 5'd15;
    localparam logic [4:0] OP_SLTU  = 5'd16;
    localparam logic [4:0] OP_LUI   = 5'd17;

    logic [4:0] op;

    // Anything not listed (JR, JALR, MFHI/MFLO, MTHI/MTLO, loads, stores) falls back to ADD.
    always_comb begin
        op = OP_ADD;
        case (bus.alu_op)
            2'b01: op = OP_SUB;
            2'b10: begin
                case (bus.function_code)
                    6'h00:   op = OP_SLL;
                    6'h02:   op = OP_SRL;
                    6'h03:   op = OP_SRA;
                    6'h04:   op = OP_SLLV;
                    6'h06:   op = OP_SRLV;
                    6'h07:   op = OP_SRAV;
                    6'h18:   op = OP_MULT;
                    6'h19:   op = OP_MULTU;
                    6'h1A:   op = OP_DIV;
                    6'h1B:   op = OP_DIVU;
                    6'h21:   op = OP_ADD;
                    6'h23:   op = OP_SUB;
                    6'h24:   op = OP_AND;
                    6'h25:   op = OP_OR;
                    6'h26:   op = OP_XOR;
                    6'h2A:   op = OP_SLT;
                    6'h2B:   op = OP_SLTU;
                    default: op = OP_ADD;
                endcase
            end
            2'b11: begin
                case (bus.opcode)
                    6'h09:   op = OP_ADD;
                    6'h0A:   op = OP_SLT;
                    6'h0B:   op = OP_SLTU;
                    6'h0C:   op = OP_AND;
                    6'h0D:   op = OP_OR;
                    6'h0E:   op = OP_XOR;
                    6'h0F:   op = OP_LUI;
                    default: op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [63:0] a_x;
    logic signed [63:0] b_x;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [4:0]  sh_amt;
    logic signed [31:0] sra_res;
    logic               div_zero;

    assign a_s      = bus.a;
    assign b_s      = bus.b;
    assign a_x      = {{32{bus.a[31]}}, bus.a};
    assign b_x      = {{32{bus.b[31]}}, bus.b};
    assign prod_s   = a_x * b_x;
    assign prod_u   = {32'h0, bus.a} * {32'h0, bus.b};
    assign quot_s   = a_s / b_s;
    assign rem_s    = a_s % b_s;
    assign div_zero = (bus.b == 32'h0);
    assign sh_amt   = (op == OP_SLLV || op == OP_SRLV || op == OP_SRAV) ? bus.a[4:0] : bus.shamt;
    assign sra_res  = b_s >>> sh_amt;

    logic [31:0] res;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    always_comb begin
        res    = bus.a + bus.b;
        hi_res = 32'h0;
        lo_res = 32'h0;
        case (op)
            OP_SUB:            res = bus.a - bus.b;
            OP_SLL,  OP_SLLV:  res = bus.b << sh_amt;
            OP_SRL,  OP_SRLV:  res = bus.b >> sh_amt;
            OP_SRA,  OP_SRAV:  res = sra_res;
            OP_AND:            res = bus.a & bus.b;
            OP_OR:             res = bus.a | bus.b;
            OP_XOR:            res = bus.a ^ bus.b;
            OP_SLT:            res = {31'h0, a_s < b_s};
            OP_SLTU:           res = {31'h0, bus.a < bus.b};
            OP_LUI:            res = {bus.b[15:0], 16'h0000};
            OP_MULT: begin
                res    = 32'h0;
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            OP_MULTU: begin
                res    = 32'h0;
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            // Divide by zero leaves the dividend in HI and clears LO; no trap.
            OP_DIV: begin
                res    = 32'h0;
                hi_res = div_zero ? bus.a : rem_s;
                lo_res = div_zero ? 32'h0 : quot_s;
            end
            OP_DIVU: begin
                res    = 32'h0;
                hi_res = div_zero ? bus.a : (bus.a % bus.b);
                lo_res = div_zero ? 32'h0 : (bus.a / bus.b);
            end
            default:           res = bus.a + bus.b;
        endcase
    end

    assign bus.alu_out = res;
    assign bus.zero    = (res == 32'h0);
    assign bus.hi      = hi_res;
    assign bus.lo      = lo_res;

    logic [31:0] tgt_sel;

    always_comb begin
        if (bus.jump2)
            tgt_sel = bus.a;
        else if (bus.jump1)
            tgt_sel = bus.jump_addr;
        else if (bus.branch && bus.condition_met)
            tgt_sel = bus.branch_addr;
        else
            tgt_sel = bus.pc_plus4;
    end

    assign bus.tgt_addr_0 = tgt_sel;

    // A not-taken branch still sets delay; the stored pc_plus4 makes that harmless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.tgt_addr_1 <= 32'h0;
            bus.delay      <= 1'b0;
        end else if (bus.clk_enable) begin
            bus.tgt_addr_1 <= tgt_sel;
            bus.delay      <= bus.branch | bus.jump1 | bus.jump2;
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit; a queue-based scoreboard checks each
// presented result against hand-computed expectations.
module tb_exec_unit;
    logic clk;
    logic reset;

    exec_unit_if bus ();

    exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_ALU = 0;
    localparam int K_TGT = 1;
    localparam int K_REG = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        z;
    } exp_t;

    exp_t q[$];
    logic strobe;
    int   checks;
    int   errors;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (strobe) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: output presented with empty queue");
            end else begin
                exp_t e;
                e = q.pop_front();
                case (e.kind)
                    K_ALU: begin
                        chk(e.name, "alu_out", bus.alu_out, e.v0);
                        chk(e.name, "zero", {31'h0, bus.zero}, {31'h0, e.z});
                        chk(e.name, "hi", bus.hi, e.v1);
                        chk(e.name, "lo", bus.lo, e.v2);
                    end
                    K_TGT: chk(e.name, "tgt_addr_0", bus.tgt_addr_0, e.v0);
                    default: begin
                        chk(e.name, "tgt_addr_1", bus.tgt_addr_1, e.v0);
                        chk(e.name, "delay", {31'h0, bus.delay}, {31'h0, e.z});
                    end
                endcase
            end
        end
    end

    task automatic present();
        strobe = 1'b1;
        @(negedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic clear_ctl();
        bus.clk_enable    = 1'b0;
        bus.branch        = 1'b0;
        bus.condition_met = 1'b0;
        bus.jump1         = 1'b0;
        bus.jump2         = 1'b0;
    endtask

    task automatic alu(input string nm, input logic [1:0] op, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] e_out, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_z);
        exp_t e;
        @(posedge clk);
        #1;
        clear_ctl();
        bus.alu_op        = op;
        bus.opcode        = opc;
        bus.function_code = fn;
        bus.shamt         = sh;
        bus.a             = av;
        bus.b             = bv;
        e.name = nm; e.kind = K_ALU; e.v0 = e_out; e.v1 = e_hi; e.v2 = e_lo; e.z = e_z;
        q.push_back(e);
        present();
    endtask

    task automatic tgt(input string nm, input logic br, input logic cm, input logic j1,
                       input logic j2, input logic [31:0] e_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        clear_ctl();
        bus.branch        = br;
        bus.condition_met = cm;
        bus.jump1         = j1;
        bus.jump2         = j2;
        bus.a             = 32'h00400010;
        e.name = nm; e.kind = K_TGT; e.v0 = e_tgt; e.v1 = 32'h0; e.v2 = 32'h0; e.z = 1'b0;
        q.push_back(e);
        present();
    endtask

    // Apply controls for one edge, then check the registered target after it.
    task automatic reg_step(input string nm, input logic rst, input logic ce,
                            input logic br, input logic cm, input logic j1, input logic j2,
                            input logic [31:0] e_tgt, input logic e_delay);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rst;
        bus.clk_enable    = ce;
        bus.branch        = br;
        bus.condition_met = cm;
        bus.jump1         = j1;
        bus.jump2         = j2;
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_ctl();
        e.name = nm; e.kind = K_REG; e.v0 = e_tgt; e.v1 = 32'h0; e.v2 = 32'h0; e.z = e_delay;
        q.push_back(e);
        present();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        strobe = 1'b0;
        reset  = 1'b0;
        clear_ctl();
        bus.alu_op        = 2'b00;
        bus.opcode        = 6'h00;
        bus.function_code = 6'h00;
        bus.shamt         = 5'd0;
        bus.a             = 32'h0;
        bus.b             = 32'h0;
        bus.branch_addr   = 32'h22222220;
        bus.jump_addr     = 32'hBFC00100;
        bus.pc_plus4      = 32'h33333330;

        reg_step("reset_init", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        alu("addu",      2'b10, 6'h00, 6'h21, 5'd0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h0, 32'h0, 1'b0);
        alu("sub_beq",   2'b01, 6'h04, 6'h00, 5'd0, 32'h12345678, 32'h12345678, 32'h00000000, 32'h0, 32'h0, 1'b1);
        alu("slt",       2'b10, 6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 1'b0);
        alu("sltu",      2'b10, 6'h00, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 32'h0, 1'b1);
        alu("sra",       2'b10, 6'h00, 6'h03, 5'd4, 32'h00000000, 32'h80000000, 32'hF8000000, 32'h0, 32'h0, 1'b0);
        alu("srav",      2'b10, 6'h00, 6'h07, 5'd0, 32'h00000024, 32'h80000000, 32'hF8000000, 32'h0, 32'h0, 1'b0);
        alu("sll",       2'b10, 6'h00, 6'h00, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 32'h0, 32'h0, 1'b0);
        alu("srl",       2'b10, 6'h00, 6'h02, 5'd4, 32'h00000000, 32'h80000000, 32'h08000000, 32'h0, 32'h0, 1'b0);
        alu("sllv",      2'b10, 6'h00, 6'h04, 5'd9, 32'h00000003, 32'h00000001, 32'h00000008, 32'h0, 32'h0, 1'b0);
        alu("srlv",      2'b10, 6'h00, 6'h06, 5'd9, 32'h00000021, 32'h80000000, 32'h40000000, 32'h0, 32'h0, 1'b0);
        alu("lui",       2'b11, 6'h0F, 6'h00, 5'd0, 32'h00000000, 32'h0000ABCD, 32'hABCD0000, 32'h0, 32'h0, 1'b0);
        alu("mult",      2'b10, 6'h00, 6'h18, 5'd0, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        alu("multu",     2'b10, 6'h00, 6'h19, 5'd0, 32'hFFFFFFFE, 32'h00000003, 32'h00000000, 32'h00000002, 32'hFFFFFFFA, 1'b1);
        alu("div",       2'b10, 6'h00, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        alu("divu_zero", 2'b10, 6'h00, 6'h1B, 5'd0, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1);
        alu("div_zero",  2'b10, 6'h00, 6'h1A, 5'd0, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 1'b1);
        alu("divu",      2'b10, 6'h00, 6'h1B, 5'd0, 32'h00000011, 32'h00000005, 32'h00000000, 32'h00000002, 32'h00000003, 1'b1);
        alu("add_mem",   2'b00, 6'h23, 6'h00, 5'd0, 32'h00000010, 32'h00000020, 32'h00000030, 32'h0, 32'h0, 1'b0);
        alu("subu",      2'b10, 6'h00, 6'h23, 5'd0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0);
        alu("and",       2'b10, 6'h00, 6'h24, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 32'h0, 1'b0);
        alu("or",        2'b10, 6'h00, 6'h25, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 32'h0, 32'h0, 1'b0);
        alu("xor",       2'b10, 6'h00, 6'h26, 5'd0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 32'h0, 32'h0, 1'b0);
        alu("jr_add",    2'b10, 6'h00, 6'h08, 5'd0, 32'h00000100, 32'h00000004, 32'h00000104, 32'h0, 32'h0, 1'b0);
        alu("addiu",     2'b11, 6'h09, 6'h00, 5'd0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0, 1'b1);
        alu("slti",      2'b11, 6'h0A, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 1'b0);
        alu("sltiu",     2'b11, 6'h0B, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 32'h0, 1'b1);
        alu("andi",      2'b11, 6'h0C, 6'h00, 5'd0, 32'h000000FF, 32'h0000000F, 32'h0000000F, 32'h0, 32'h0, 1'b0);
        alu("ori",       2'b11, 6'h0D, 6'h00, 5'd0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 32'h0, 32'h0, 1'b0);
        alu("xori",      2'b11, 6'h0E, 6'h00, 5'd0, 32'h000000FF, 32'h0000000F, 32'h000000F0, 32'h0, 32'h0, 1'b0);
        alu("opc_other", 2'b11, 6'h23, 6'h00, 5'd0, 32'h00000008, 32'h00000004, 32'h0000000C, 32'h0, 32'h0, 1'b0);

        tgt("j1_j2",     1'b1, 1'b1, 1'b1, 1'b1, 32'h00400010);
        tgt("jump1",     1'b1, 1'b1, 1'b1, 1'b0, 32'hBFC00100);
        tgt("br_taken",  1'b1, 1'b1, 1'b0, 1'b0, 32'h22222220);
        tgt("br_not",    1'b1, 1'b0, 1'b0, 1'b0, 32'h33333330);
        tgt("seq",       1'b0, 1'b1, 1'b0, 1'b0, 32'h33333330);

        reg_step("reg_jump",   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBFC00100, 1'b1);
        reg_step("reg_hold",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC00100, 1'b1);
        reg_step("reg_seq",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33333330, 1'b0);
        reg_step("reg_br_not", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33333330, 1'b1);
        reg_step("reg_jr",     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400010, 1'b1);
        reg_step("reg_reset",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute-stage block of the multicycle MIPS-I CPU. Merges three functions: ALU control decode, the 32-bit ALU with HI/LO product/quotient outputs, and next-PC target selection.
- Also holds a registered branch/jump target and a "redirect pending" flag. The PC mux uses them in the fetch after a control-transfer instruction, which implements the branch delay slot.
- ALU and target-select paths are purely combinational. Only the target holder is clocked.

Parameters:
- None. Data width fixed at 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- clk_enable  in  1  high for exactly one cycle per instruction (EXEC); enables the target register update
- alu_op  in  2  from control: 00 add, 01 subtract, 10 R-type (decode funct), 11 I-type (decode opcode)
- opcode  in  6  instr[31:26]
- function_code  in  6  instr[5:0]
- shamt  in  5  instr[10:6]
- a  in  32  rs read data
- b  in  32  rt data or extended immediate (already muxed)
- branch  in  1  instruction is a conditional branch
- condition_met  in  1  branch condition true
- jump1  in  1  J/JAL
- jump2  in  1  JR/JALR
- branch_addr  in  32  PC+4 + (sign-extended imm << 2)
- jump_addr  in  32  {pc_plus4[31:28], instr[25:0], 2'b00}
- pc_plus4  in  32  current PC + 4
- alu_out  out  32  ALU result
- zero  out  1  high when alu_out == 0
- hi  out  32  MULT/DIV upper result
- lo  out  32  MULT/DIV lower result
- tgt_addr_0  out  32  combinational selected target
- tgt_addr_1  out  32  registered target
- delay  out  1  registered: next fetch uses tgt_addr_1

Behaviour:
- Control decode, alu_op 00: ADD (A+B, wrap, no overflow trap). Used by loads and stores.
- Control decode, alu_op 01: SUB (A-B). Used by BEQ/BNE via zero.
- Control decode, alu_op 10 (funct, hex): 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU, 21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 2A SLT, 2B SLTU.
- alu_op 10, any other funct (JR, JALR, MFHI, MFLO, MTHI, MTLO, unknown): ADD.
- Control decode, alu_op 11 (opcode, hex): 09 ADDIU, 0A SLTI, 0B SLTIU, 0C ANDI, 0D ORI, 0E XORI, 0F LUI. Any other opcode: ADD.
- Shift by amount: B shifted by shamt.
- Variable shifts: B shifted by A[4:0]. SRA/SRAV replicate B[31].
- SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare. Result 32'h1 or 32'h0.
- LUI: alu_out = {B[15:0], 16'h0000}.
- MULT/MULTU: 64-bit signed/unsigned product; hi = [63:32], lo = [31:0]. alu_out = 0.
- DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend. alu_out = 0.
- Divide by zero: lo = 0, hi = A. No exception.
- hi and lo = 0 for every non-MULT/DIV operation.
- zero reflects alu_out for every operation.
- tgt_addr_0 priority: jump2 → a; else jump1 → jump_addr; else (branch & condition_met) → branch_addr; else pc_plus4.
- Rising edge of clk with reset = 0: tgt_addr_1 <= 0, delay <= 0. Reset overrides clk_enable.
- Rising edge with reset = 1 and clk_enable = 1: tgt_addr_1 <= tgt_addr_0; delay <= branch | jump1 | jump2. A not-taken branch therefore stores pc_plus4 with delay = 1, which is harmless.
- Rising edge with reset = 1 and clk_enable = 0: both registers hold.
- jump1 and jump2 both high: jump2 wins.
- No X propagation: all outputs defined for every input combination.

Test Plan:
- ADDU: alu_op 10, funct 21, a = FFFFFFFF, b = 00000002 → alu_out = 00000001, zero = 0.
- SUB for branch: alu_op 01, a = b = 12345678 → alu_out = 0, zero = 1.
- Signed vs unsigned compare: alu_op 10, funct 2A, a = FFFFFFFF, b = 1 → 1. Same operands with funct 2B → 0.
- SRA: funct 03, b = 80000000, shamt = 4 → F8000000.
- SRAV: funct 07, a = 24 (shift uses A[4:0] = 4), b = 80000000 → F8000000.
- LUI: alu_op 11, opcode 0F, b = 0000ABCD → ABCD0000.
- MULT: a = FFFFFFFE (-2), b = 3 → hi = FFFFFFFF, lo = FFFFFFFA.
- MULTU on the same operands → hi = 00000002, lo = FFFFFFFA.
- DIV: a = -7, b = 2 → lo = FFFFFFFD, hi = FFFFFFFF.
- DIVU: b = 0, a = 5 → lo = 0, hi = 5.
- Target select: jump1 = jump2 = 1, a = 00400010 → tgt_addr_0 = 00400010.
- Target select: branch = 1, condition_met = 0 → tgt_addr_0 = pc_plus4.
- Register timing: pulse clk_enable with jump1 = 1, jump_addr = BFC00100 → next edge tgt_addr_1 = BFC00100, delay = 1.
- Following edge with clk_enable = 0 → tgt_addr_1 and delay unchanged.
- Next clk_enable pulse with no branch/jump → delay = 0.
- Reset: hold reset = 0 while clk_enable = 1 → tgt_addr_1 = 0, delay = 0.
